// File: rtl/audio_pkg.sv
// Shared audio-path defaults, the mixer state encoding and the per-source control record.
package audio_pkg;

  localparam int DEF_N_SRC       = 6;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_VOLUME_BITS = 8;
  localparam int DEF_M_BUF_LEN   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CLAMP = 2'd2,
    WRITE = 2'd3
  } MixState_t;

  typedef struct packed {
    logic                              en;
    logic [DEF_VOLUME_BITS-1:0]        vol;
    logic signed [DEF_SAMPLE_BITS-1:0] sample;
  } SourceControlReg_t;

endpackage

// File: rtl/lrclk_edge_sync.sv
// Brings the I2S frame clock into the mclk domain and flags its falling edge.
module lrclk_edge_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic lrclk_i,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic edge_q;

  // All three flops reset high so a low-going edge can never appear at reset release.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
    end else begin
      sync1_q <= lrclk_i;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign fall_o = edge_q & ~sync2_q;

endmodule

// File: rtl/mix_scheduler.sv
// Per-frame weighted mixer of N_SRC sources into the master playback buffer.
// Define MIX_SATURATE_EN to clamp the mix (with clip pulse); otherwise it wraps.
module mix_scheduler
  import audio_pkg::*;
#(
  parameter int N_SRC       = DEF_N_SRC,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int VOLUME_BITS = DEF_VOLUME_BITS,
  parameter int M_BUF_LEN   = DEF_M_BUF_LEN
) (
  input  logic                           mclk,
  input  logic                           rstn,
  input  logic                           pblrc,
  input  logic [N_SRC*SAMPLE_BITS-1:0]   src_sample,
  input  logic [N_SRC*VOLUME_BITS-1:0]   src_vol,
  input  logic [N_SRC-1:0]               src_en,
  input  logic [7:0]                     play_index,
  output logic                           buf_wr_en,
  output logic [$clog2(M_BUF_LEN)-1:0]   buf_wr_addr,
  output logic [SAMPLE_BITS-1:0]         buf_wr_data,
  output logic                           busy,
  output logic                           overrun,
  output logic                           clip
);

  localparam int AW    = $clog2(M_BUF_LEN);
  localparam int CW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int ACC_W = SAMPLE_BITS + $clog2(N_SRC) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_SRC - 1);

  logic frameStart;

  lrclk_edge_sync u_sync (
    .clk_i  (mclk),
    .rstn_i (rstn),
    .lrclk_i(pblrc),
    .fall_o (frameStart)
  );

  MixState_t                        state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [N_SRC*SAMPLE_BITS-1:0]     sample_q, sample_d;
  logic [N_SRC*VOLUME_BITS-1:0]     vol_q, vol_d;
  logic [N_SRC-1:0]                 en_q, en_d;
  logic [7:0]                       pidx_q, pidx_d;
  logic [AW-1:0]                    wrAddr_q, wrAddr_d;
  logic [SAMPLE_BITS-1:0]           wrData_q, wrData_d;
  logic                             clip_q, clip_d;

  logic signed [SAMPLE_BITS-1:0]           curSample;
  logic [VOLUME_BITS-1:0]                  curVol;
  logic signed [SAMPLE_BITS+VOLUME_BITS:0] product;
  logic signed [SAMPLE_BITS+VOLUME_BITS:0] scaled;
  logic signed [ACC_W-1:0]                 term;
  logic [SAMPLE_BITS-1:0]                  clamped;
  logic                                    clipNext;

  // Gain is treated as an unsigned fraction of full scale, so the product is floored by the shift.
  always_comb begin
    curSample = $signed(sample_q[int'(cnt_q)*SAMPLE_BITS +: SAMPLE_BITS]);
    curVol    = vol_q[int'(cnt_q)*VOLUME_BITS +: VOLUME_BITS];
    product   = curSample * $signed({1'b0, curVol});
    scaled    = product >>> VOLUME_BITS;
    term      = en_q[cnt_q] ? ACC_W'(scaled) : '0;
  end

`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_ACC =
    {{(ACC_W-SAMPLE_BITS+1){1'b0}}, {(SAMPLE_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_ACC =
    {{(ACC_W-SAMPLE_BITS+1){1'b1}}, {(SAMPLE_BITS-1){1'b0}}};

  always_comb begin
    clamped  = acc_q[SAMPLE_BITS-1:0];
    clipNext = 1'b0;
    if (acc_q > MAX_ACC) begin
      clamped  = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
      clipNext = 1'b1;
    end else if (acc_q < MIN_ACC) begin
      clamped  = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
      clipNext = 1'b1;
    end
  end
`else
  always_comb begin
    clamped  = acc_q[SAMPLE_BITS-1:0];
    clipNext = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    vol_d    = vol_q;
    en_d     = en_q;
    pidx_d   = pidx_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    clip_d   = clip_q;
    unique case (state_q)
      IDLE: begin
        if (frameStart) begin
          sample_d = src_sample;
          vol_d    = src_vol;
          en_d     = src_en;
          pidx_d   = play_index;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + term;
        if (cnt_q == LAST_CNT) begin
          state_d = CLAMP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLAMP: begin
        // Write one slot behind playback; the power-of-two wrap handles index 0.
        wrAddr_d = AW'(pidx_q - 8'd1);
        wrData_d = clamped;
        clip_d   = clipNext;
        state_d  = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      vol_q    <= '0;
      en_q     <= '0;
      pidx_q   <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      vol_q    <= vol_d;
      en_q     <= en_d;
      pidx_q   <= pidx_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      clip_q   <= clip_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign buf_wr_en   = (state_q == WRITE);
  assign buf_wr_addr = wrAddr_q;
  assign buf_wr_data = wrData_q;
  assign clip        = (state_q == WRITE) & clip_q;
  assign overrun     = frameStart & (state_q != IDLE);

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler: latency, mixing, address wrap, overrun and reset abort.
module tb_mix_scheduler;

  localparam int N_SRC = 6;
  localparam int SB    = 16;
  localparam int VB    = 8;
  localparam int MB    = 32;

  logic              mclk = 1'b0;
  logic              rstn = 1'b0;
  logic              pblrc = 1'b1;
  logic [N_SRC*SB-1:0] src_sample = '0;
  logic [N_SRC*VB-1:0] src_vol = '0;
  logic [N_SRC-1:0]  src_en = '0;
  logic [7:0]        play_index = '0;
  logic              buf_wr_en;
  logic [4:0]        buf_wr_addr;
  logic [SB-1:0]     buf_wr_data;
  logic              busy;
  logic              overrun;
  logic              clip;

  int nChecks = 0;
  int nFails  = 0;

  int          firstWr;
  int          firstBusy;
  int          wrCount;
  int          ovCount;
  logic [15:0] wrData;
  logic [4:0]  wrAddr;
  logic        wrClip;

  mix_scheduler #(
    .N_SRC(N_SRC), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .M_BUF_LEN(MB)
  ) dut (
    .mclk       (mclk),
    .rstn       (rstn),
    .pblrc      (pblrc),
    .src_sample (src_sample),
    .src_vol    (src_vol),
    .src_en     (src_en),
    .play_index (play_index),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data),
    .busy       (busy),
    .overrun    (overrun),
    .clip       (clip)
  );

  always #5 mclk = ~mclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setSrc(input int i, input int s, input int v);
    src_sample[i*SB +: SB] = s[15:0];
    src_vol[i*VB +: VB]    = v[7:0];
  endtask

  task automatic clearSrc();
    src_sample = '0;
    src_vol    = '0;
    src_en     = '0;
  endtask

  // Drops pblrc and watches 30 cycles; index k is the cycle following the k-th rising edge.
  task automatic applyStimulus(input logic dbl);
    firstWr   = 0;
    firstBusy = 0;
    wrCount   = 0;
    ovCount   = 0;
    wrData    = '0;
    wrAddr    = '0;
    wrClip    = 1'b0;
    @(negedge mclk);
    pblrc = 1'b0;
    for (int idx = 1; idx <= 30; idx++) begin
      @(posedge mclk);
      #1;
      if (busy && firstBusy == 0) firstBusy = idx;
      if (buf_wr_en) begin
        if (wrCount == 0) begin
          firstWr = idx;
          wrData  = buf_wr_data;
          wrAddr  = buf_wr_addr;
          wrClip  = clip;
        end
        wrCount++;
      end
      if (overrun) ovCount++;
      if (dbl && idx == 2) pblrc = 1'b1;
      if (dbl && idx == 3) pblrc = 1'b0;
    end
    pblrc = 1'b1;
    repeat (4) @(posedge mclk);
    #1;
  endtask

  initial begin
    logic        satBuild;
    logic [15:0] satData;
`ifdef MIX_SATURATE_EN
    satBuild = 1'b1;
    satData  = 16'h7FFF;
`else
    satBuild = 1'b0;
    // Each source contributes floor(30000*255/256) = 29882; six sum to 179292, low 16 bits 0xBC5C.
    satData  = 16'hBC5C;
`endif

    repeat (3) @(posedge mclk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_en", 32'(buf_wr_en), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_clip", 32'(clip), 32'd0);
    checkOutput("rst_data", 32'(buf_wr_data), 32'd0);
    checkOutput("rst_addr", 32'(buf_wr_addr), 32'd0);
    @(negedge mclk);
    rstn = 1'b1;
    repeat (5) @(posedge mclk);
    #1;
    checkOutput("release_no_frame", 32'(busy), 32'd0);

    $display("[TB] single source");
    clearSrc();
    setSrc(0, 1000, 128);
    src_en     = 6'b000001;
    play_index = 8'd5;
    applyStimulus(1'b0);
    checkOutput("single_busy_cycle", 32'(firstBusy), 32'd3);
    checkOutput("single_latency", 32'(firstWr), 32'd10);
    checkOutput("single_wr_count", 32'(wrCount), 32'd1);
    checkOutput("single_overrun", 32'(ovCount), 32'd0);
    checkOutput("single_data", 32'(wrData), 32'd500);
    checkOutput("single_addr", 32'(wrAddr), 32'd4);
    checkOutput("single_clip", 32'(wrClip), 32'd0);
    checkOutput("hold_wr_en", 32'(buf_wr_en), 32'd0);
    checkOutput("hold_data", 32'(buf_wr_data), 32'd500);
    checkOutput("hold_addr", 32'(buf_wr_addr), 32'd4);

    $display("[TB] saturation");
    for (int i = 0; i < N_SRC; i++) setSrc(i, 30000, 255);
    src_en     = 6'b111111;
    play_index = 8'd0;
    applyStimulus(1'b0);
    checkOutput("sat_data", 32'(wrData), 32'(satData));
    checkOutput("sat_clip", 32'(wrClip), 32'(satBuild));
    checkOutput("sat_addr_wrap0", 32'(wrAddr), 32'd31);
    checkOutput("sat_wr_count", 32'(wrCount), 32'd1);

    $display("[TB] address wrap");
    clearSrc();
    setSrc(0, 1000, 128);
    src_en     = 6'b000001;
    play_index = 8'd33;
    applyStimulus(1'b0);
    checkOutput("wrap_addr", 32'(wrAddr), 32'd0);
    checkOutput("wrap_data", 32'(wrData), 32'd500);

    $display("[TB] mixed signs");
    clearSrc();
    setSrc(0, 1000, 128);
    setSrc(1, -4000, 64);
    setSrc(2, 300, 255);
    setSrc(3, 5000, 200);
    src_en     = 6'b000111;
    play_index = 8'd17;
    applyStimulus(1'b0);
    checkOutput("mix_data", 32'(wrData), 32'h0000FF36);
    checkOutput("mix_addr", 32'(wrAddr), 32'd16);

    $display("[TB] mute");
    clearSrc();
    setSrc(0, -2000, 255);
    setSrc(1, 2000, 255);
    src_en     = 6'b000001;
    play_index = 8'd1;
    applyStimulus(1'b0);
    checkOutput("mute_data", 32'(wrData), 32'h0000F837);
    checkOutput("mute_addr", 32'(wrAddr), 32'd0);

    $display("[TB] overrun");
    clearSrc();
    setSrc(0, 1000, 128);
    src_en     = 6'b000001;
    play_index = 8'd5;
    applyStimulus(1'b1);
    checkOutput("ovr_pulses", 32'(ovCount), 32'd1);
    checkOutput("ovr_wr_count", 32'(wrCount), 32'd1);
    checkOutput("ovr_latency", 32'(firstWr), 32'd10);
    checkOutput("ovr_data", 32'(wrData), 32'd500);

    $display("[TB] reset mid-frame");
    @(negedge mclk);
    pblrc = 1'b0;
    repeat (5) @(posedge mclk);
    #1;
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    rstn  = 1'b0;
    pblrc = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_wr_en", 32'(buf_wr_en), 32'd0);
    checkOutput("midrst_data", 32'(buf_wr_data), 32'd0);
    @(negedge mclk);
    rstn = 1'b1;
    wrCount = 0;
    for (int idx = 0; idx < 20; idx++) begin
      @(posedge mclk);
      #1;
      if (buf_wr_en) wrCount++;
    end
    checkOutput("midrst_no_write", 32'(wrCount), 32'd0);
    clearSrc();
    setSrc(0, 1000, 128);
    setSrc(1, -4000, 64);
    setSrc(2, 300, 255);
    src_en     = 6'b000111;
    play_index = 8'd17;
    applyStimulus(1'b0);
    checkOutput("postrst_data", 32'(wrData), 32'h0000FF36);
    checkOutput("postrst_addr", 32'(wrAddr), 32'd16);
    checkOutput("postrst_wr_count", 32'(wrCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
